alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle control and register stage that sits directly upstream of the processor ALU. It accepts one 16-bit instruction per Run request and holds the general-purpose register file R0–R7. It drives the ALU operand and opcode lines, captures the ALU result into G, and writes it back to the destination register. Move and move-immediate instructions complete without using the ALU.

## Interface
- n, 16, datapath and register width
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Run  in  1  instruction request, sampled only in IDLE
- DIN  in  n  instruction word when Run is accepted; immediate operand in the following cycle (mvi)
- alu_result  in  n  combinational result returned by ALU
- alu_a  out  n  ALU operand A, equals register A
- alu_b  out  n  ALU operand b, equals R[Y]
- alu_op  out  4  ALU opcode, equals IR[15:12]
- alu_addsub  out  1  1 when IR[15:12]=0001 (sub), else 0
- Done  out  1  high for exactly one cycle, the last cycle of each instruction
- Busy  out  1  high whenever state ≠ IDLE
- rd_sel  in  3  register readback select
- rd_data  out  n  R[rd_sel], combinational

## Operation
- Instruction format: IR[15:12] opcode, IR[11:9] X (destination/first source), IR[8:6] Y (second source), IR[5:0] ignored.
- ALU opcodes:
  - 0000 add
  - 0001 sub
  - 0010 slt
  - 0011 sll
  - 0100 slr
  - 0101 and
- Non-ALU opcodes:
  - 0110 mv, R[X] ← R[Y]
  - 0111 mvi, R[X] ← DIN
  - 1000–1111 nop
- State registers: R0–R7, IR, A, G, state. All are n bits except state. All reset to 0; state resets to IDLE.
- FSM states IDLE, T1, T2, T3:
  - IDLE: if Run=1, IR ← DIN and go to T1; else stay. Done=0, Busy=0.
  - T1, mv: R[X] ← R[Y], Done=1, go to IDLE.
  - T1, mvi: R[X] ← DIN, Done=1, go to IDLE.
  - T1, nop: no register write, Done=1, go to IDLE.
  - T1, ALU op: A ← R[X], go to T2.
  - T2: ALU sees a=A, b=R[Y], op=IR[15:12]; G ← alu_result; go to T3.
  - T3: R[X] ← G, Done=1, go to IDLE.
- Run is ignored in T1–T3. A request held high through Done is taken as a new instruction at the first IDLE edge.
- X=Y is legal. Source reads use pre-edge values, e.g. add R2,R2 doubles R2.
- No arithmetic in this block. Results are exactly the n-bit ALU output. Wrap-around, slt 0/1, and shift amounts ≥ n are ALU-defined and written back unmodified.
- Reset asserted in any state:
  - Immediately forces IDLE and clears all registers, IR, A and G.
  - Done and Busy go to 0 without waiting for a clock edge.
  - No pending writeback occurs.

## Timing
- Edges numbered from the edge that accepts Run (edge 0).
- ALU instruction:
  - edge 1: A loaded
  - edge 2: G loaded
  - Done high during cycle T3, i.e. between edges 2 and 3
  - edge 3: R[X] written
  - Total 3 cycles after accept.
- mv, mvi, nop:
  - Done high between edges 0 and 1
  - edge 1: R[X] written (mv/mvi)
  - Total 1 cycle.
- The mvi immediate must be valid on DIN during T1, the cycle after the instruction.
- Minimum back-to-back spacing: ALU op 4 cycles, mv/mvi/nop 2 cycles, both including IDLE.
- rd_data reflects a write on the cycle after the write edge.
- alu_a, alu_b, alu_op and alu_addsub are combinational from IR, A and the register file. After reset they read 0, 0 (R[0]), 0000 and 0.

## Test plan
- Reset → rd_data=0x0000 for all rd_sel, Done=0, Busy=0, alu_op=0000. Pulse Run with DIN=0 while Reset is still high → no state change.
- mvi R0,0x0005 then mvi R1,0x0003 → each shows Done one cycle after accept; then R0=0x0005, R1=0x0003.
- add R0,R1 (DIN=0x0040) → Busy for 3 cycles, Done in cycle 3, alu_a=0x0005 and alu_b=0x0003 in T2; then R0=0x0008, R1 unchanged.
- sub R2,R3 with R2=0x0000, R3=0x0001 → R2=0xFFFF, alu_addsub=1 during the instruction. slt R1,R0 (3<8) → R1=0x0001.
- Run held high through an entire add, and a Run pulse during T2 → the second instruction starts only at the first IDLE edge after Done; the mid-instruction pulse is not executed.
- Assert Reset asynchronously during T2 of and R4,R5 → Busy and Done drop immediately, all registers read 0, no writeback. After release, mv R6,R7 completes normally with R6=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle instruction sequencer and R0-R7 register file feeding an external ALU.
module alu_sequencer #(
    parameter int n = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [n-1:0] DIN,
    input  logic [n-1:0] alu_result,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_addsub,
    output logic         Done,
    output logic         Busy,
    input  logic [2:0]   rd_sel,
    output logic [n-1:0] rd_data
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    state_t       state;
    logic [n-1:0] r [8];
    logic [15:6]  ir;
    logic [n-1:0] a;
    logic [n-1:0] g;
    logic [2:0]   x;
    logic [2:0]   y;
    logic         is_alu;
    assign x          = ir[11:9];
    assign y          = ir[8:6];
    assign alu_op     = ir[15:12];
    assign is_alu     = ir[15:12] <= 4'd5;
    assign alu_a      = a;
    assign alu_b      = r[y];
    assign alu_addsub = ir[15:12] == 4'd1;
    assign rd_data    = r[rd_sel];
    // Done is registered: on accept it is set straight away for single-cycle opcodes
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            Done  <= 1'b0;
            Busy  <= 1'b0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else begin
            case (state)
                IDLE: if (Run) begin
                    ir    <= DIN[15:6];
                    state <= T1;
                    Busy  <= 1'b1;
                    Done  <= DIN[15:12] > 4'd5;
                end
                T1: if (is_alu) begin
                    a     <= r[x];
                    state <= T2;
                end else begin
                    if (ir[15:12] == 4'd6) r[x] <= r[y];
                    if (ir[15:12] == 4'd7) r[x] <= DIN;
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
                T2: begin
                    g     <= alu_result;
                    state <= T3;
                    Done  <= 1'b1;
                end
                T3: begin
                    r[x]  <= g;
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
